// File: rtl/bch_error_corrector.sv
// Two-error BCH(15,7) corrector: closed-form locator solve, serial Chien search, bit flip.
// Optional macro BCH_DIVIDE_EN adds a serial divide by g(x) to recover the message.
module bch_error_corrector #(
    parameter int          N       = 15,
    parameter int          K       = 7,
    parameter logic [4:0]  GF_POLY = 5'b10011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [14:0] in_codeword,
    input  logic [3:0]  in_s1,
    input  logic [3:0]  in_s3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [14:0] out_codeword,
    output logic [1:0]  out_err_cnt,
    output logic        out_uncorrectable,
    output logic [6:0]  out_message
);

    generate
        if (N != 15 || K != 7) begin : g_param_check
            $error("bch_error_corrector supports only N=15, K=7");
        end
    endgenerate

    localparam logic [3:0] ALPHA14 = 4'h9;
    localparam logic [3:0] ALPHA13 = 4'hD;

    typedef enum logic [2:0] {IDLE, SOLVE, CHIEN, DIVIDE, OUTPUT} state_t;

    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] acc;
        logic [3:0] sh;
        acc = 4'h0;
        sh  = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = sh[3] ? ({sh[2:0], 1'b0} ^ GF_POLY[3:0]) : {sh[2:0], 1'b0};
        end
        return acc;
    endfunction

    function automatic logic [3:0] gf_inv(input logic [3:0] a);
        case (a)
            4'h1:    return 4'h1;
            4'h2:    return 4'h9;
            4'h3:    return 4'hE;
            4'h4:    return 4'hD;
            4'h5:    return 4'hB;
            4'h6:    return 4'h7;
            4'h7:    return 4'h6;
            4'h8:    return 4'hF;
            4'h9:    return 4'h2;
            4'hA:    return 4'hC;
            4'hB:    return 4'h5;
            4'hC:    return 4'hA;
            4'hD:    return 4'h4;
            4'hE:    return 4'h3;
            4'hF:    return 4'h8;
            default: return 4'h0;
        endcase
    endfunction

    state_t      state;
    state_t      next_state;
    logic [14:0] word;
    logic [14:0] orig;
    logic [3:0]  s1;
    logic [3:0]  s3;
    logic [3:0]  r1;
    logic [3:0]  r2;
    logic [1:0]  deg;
    logic [1:0]  root_cnt;
    logic [1:0]  err_cnt;
    logic        unc;
    logic [3:0]  j;

    logic [3:0]  s1_cube;
    logic [3:0]  sigma2_sol;
    logic [1:0]  deg_sol;
    logic        root;
    logic [1:0]  root_cnt_next;
    logic [14:0] flip_word;

`ifdef BCH_DIVIDE_EN
    localparam logic [8:0] G_POLY = 9'h1D1;
    logic [2:0]  div_cnt;
    logic [14:0] rem;
    logic [6:0]  quot;
    logic [6:0]  message;
    logic [2:0]  div_shift;
    logic [14:0] rem_probe;
    logic        div_top;
    logic [14:0] rem_next;

    // One long-division step: quotient bit position shrinks from 6 down to 0.
    always_comb begin
        div_shift = 3'd7 - div_cnt;
        rem_probe = rem >> (4'd8 + {1'b0, div_shift});
        div_top   = (div_cnt != 3'd0) && rem_probe[0];
        if (div_top) begin
            rem_next = rem ^ ({6'b0, G_POLY} << div_shift);
        end else begin
            rem_next = rem;
        end
    end

    assign out_message = message;
`else
    assign out_message = 7'b0;
`endif

    // Peterson closed-form solution for the t=2 locator.
    always_comb begin
        s1_cube    = gf_mul(gf_mul(s1, s1), s1);
        sigma2_sol = 4'h0;
        deg_sol    = 2'd0;
        if (s1 == 4'h0) begin
            deg_sol = 2'd0;
        end else if (s3 == s1_cube) begin
            deg_sol = 2'd1;
        end else begin
            deg_sol    = 2'd2;
            sigma2_sol = gf_mul(s3 ^ s1_cube, gf_inv(s1));
        end
    end

    // Chien evaluation of sigma(alpha^-j) for the current position.
    always_comb begin
        root          = (deg != 2'd0) && ((4'h1 ^ r1 ^ r2) == 4'h0);
        root_cnt_next = root_cnt + {1'b0, root};
        flip_word     = word ^ ({14'b0, root} << j);
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) next_state = SOLVE;
                else                      next_state = IDLE;
            end
            SOLVE: next_state = CHIEN;
            CHIEN: begin
                if (j == 4'd14) begin
`ifdef BCH_DIVIDE_EN
                    next_state = DIVIDE;
`else
                    next_state = OUTPUT;
`endif
                end else begin
                    next_state = CHIEN;
                end
            end
            DIVIDE: begin
`ifdef BCH_DIVIDE_EN
                if (div_cnt == 3'd7) next_state = OUTPUT;
                else                 next_state = DIVIDE;
`else
                next_state = IDLE;
`endif
            end
            OUTPUT: begin
                if (out_valid && out_ready) next_state = IDLE;
                else                        next_state = OUTPUT;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Datapath: capture, solve, search, optional divide and output hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready          <= 1'b1;
            out_valid         <= 1'b0;
            out_codeword      <= 15'h0;
            out_err_cnt       <= 2'd0;
            out_uncorrectable <= 1'b0;
            word              <= 15'h0;
            orig              <= 15'h0;
            s1                <= 4'h0;
            s3                <= 4'h0;
            r1                <= 4'h0;
            r2                <= 4'h0;
            deg               <= 2'd0;
            root_cnt          <= 2'd0;
            err_cnt           <= 2'd0;
            unc               <= 1'b0;
            j                 <= 4'd0;
`ifdef BCH_DIVIDE_EN
            div_cnt           <= 3'd0;
            rem               <= 15'h0;
            quot              <= 7'h0;
            message           <= 7'h0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        word <= in_codeword;
                        orig <= in_codeword;
                        s1   <= in_s1;
                        s3   <= in_s3;
                    end
                end
                SOLVE: begin
                    deg      <= deg_sol;
                    r1       <= s1;
                    r2       <= sigma2_sol;
                    unc      <= (s1 == 4'h0) && (s3 != 4'h0);
                    root_cnt <= 2'd0;
                    j        <= 4'd0;
`ifdef BCH_DIVIDE_EN
                    div_cnt  <= 3'd0;
`endif
                end
                CHIEN: begin
                    r1       <= gf_mul(r1, ALPHA14);
                    r2       <= gf_mul(r2, ALPHA13);
                    j        <= j + 4'd1;
                    root_cnt <= root_cnt_next;
                    err_cnt  <= root_cnt_next;
                    // A locator whose root count disagrees with its degree cannot be trusted.
                    if ((j == 4'd14) && (root_cnt_next != deg)) begin
                        word <= orig;
                        unc  <= 1'b1;
                    end else begin
                        word <= flip_word;
                    end
                end
                DIVIDE: begin
`ifdef BCH_DIVIDE_EN
                    div_cnt <= div_cnt + 3'd1;
                    if (div_cnt == 3'd0) begin
                        rem  <= word;
                        quot <= 7'h0;
                    end else begin
                        rem  <= rem_next;
                        quot <= quot | ({6'b0, div_top} << div_shift);
                        if ((div_cnt == 3'd7) && (rem_next[7:0] != 8'h0)) unc <= 1'b1;
                    end
`endif
                end
                OUTPUT: begin
                    if (!out_valid) begin
                        out_valid         <= 1'b1;
                        out_codeword      <= word;
                        out_err_cnt       <= err_cnt;
                        out_uncorrectable <= unc;
`ifdef BCH_DIVIDE_EN
                        message           <= quot;
`endif
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
            in_ready <= (next_state == IDLE);
        end
    end

endmodule

// File: tb/tb_bch_error_corrector.sv
// Table-driven bench for bch_error_corrector with a scoreboard queue of expected results.
module tb_bch_error_corrector;

`ifdef BCH_DIVIDE_EN
    localparam int LAT = 25;
`else
    localparam int LAT = 17;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] in_codeword;
    logic [3:0]  in_s1;
    logic [3:0]  in_s3;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] out_codeword;
    logic [1:0]  out_err_cnt;
    logic        out_uncorrectable;
    logic [6:0]  out_message;

    always #5 clk = ~clk;

    bch_error_corrector dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_codeword      (in_codeword),
        .in_s1            (in_s1),
        .in_s3            (in_s3),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_codeword     (out_codeword),
        .out_err_cnt      (out_err_cnt),
        .out_uncorrectable(out_uncorrectable),
        .out_message      (out_message)
    );

    typedef struct {
        logic [14:0] cw;
        logic [3:0]  s1;
        logic [3:0]  s3;
        logic [14:0] exp_cw;
        logic [1:0]  exp_cnt;
        logic        exp_unc;
        logic [6:0]  exp_msg;
    } vec_t;

    vec_t       vecs[$];
    vec_t       exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] apow [0:14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [14:0] clmul_g(input logic [6:0] m);
        logic [14:0] p;
        p = 15'h0;
        for (int i = 0; i < 7; i++) begin
            if (m[i]) p = p ^ (15'h01D1 << i);
        end
        return p;
    endfunction

    function automatic void div_g(input logic [14:0] c, output logic [6:0] q, output logic [7:0] r);
        logic [14:0] t;
        t = c;
        q = 7'h0;
        for (int i = 14; i >= 8; i--) begin
            if (t[i]) begin
                t = t ^ (15'h01D1 << (i - 8));
                q[i - 8] = 1'b1;
            end
        end
        r = t[7:0];
    endfunction

    function automatic vec_t mk(input logic [14:0] cw, input logic [3:0] s1, input logic [3:0] s3,
                                input logic [14:0] exp_cw, input logic [1:0] cnt, input logic unc);
        vec_t       v;
        logic [6:0] q;
        logic [7:0] r;
        v.cw      = cw;
        v.s1      = s1;
        v.s3      = s3;
        v.exp_cw  = exp_cw;
        v.exp_cnt = cnt;
        v.exp_unc = unc;
        v.exp_msg = 7'h0;
        div_g(exp_cw, q, r);
`ifdef BCH_DIVIDE_EN
        v.exp_msg = q;
        if (r != 8'h0) v.exp_unc = 1'b1;
`endif
        return v;
    endfunction

    // Build a codeword from a message, inject errors and derive syndromes from the alpha table.
    function automatic vec_t mk_gen(input logic [6:0] m, input logic [14:0] e);
        logic [14:0] c;
        logic [14:0] r;
        logic [3:0]  s1;
        logic [3:0]  s3;
        c  = clmul_g(m);
        r  = c ^ e;
        s1 = 4'h0;
        s3 = 4'h0;
        for (int k = 0; k < 15; k++) begin
            if (r[k]) begin
                s1 = s1 ^ apow[k];
                s3 = s3 ^ apow[(3 * k) % 15];
            end
        end
        return mk(r, s1, s3, c, 2'($countones(e)), 1'b0);
    endfunction

    task automatic chk_out(input vec_t e, input string tag);
        chk({tag, " codeword"}, 32'(out_codeword), 32'(e.exp_cw));
        chk({tag, " err_cnt"}, 32'(out_err_cnt), 32'(e.exp_cnt));
        chk({tag, " uncorrectable"}, 32'(out_uncorrectable), 32'(e.exp_unc));
        chk({tag, " message"}, 32'(out_message), 32'(e.exp_msg));
    endtask

    task automatic run_vec(input vec_t v, input int hold, input string tag);
        int   w;
        int   lat;
        vec_t e;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
        in_valid    = 1'b1;
        in_codeword = v.cw;
        in_s1       = v.s1;
        in_s3       = v.s3;
        out_ready   = (hold == 0);
        @(posedge clk);
        exp_q.push_back(v);
        #1;
        in_valid = 1'b0;
        chk({tag, " in_ready after accept"}, 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            lat++;
            #1;
        end
        chk({tag, " latency"}, 32'(lat), 32'(LAT));
        if (out_valid) begin
            e = exp_q.pop_front();
            chk_out(e, tag);
            for (int k = 0; k < hold; k++) begin
                @(posedge clk);
                #1;
                chk({tag, " held out_valid"}, 32'(out_valid), 32'd1);
                chk({tag, " held in_ready"}, 32'(in_ready), 32'd0);
                chk_out(e, {tag, " held"});
            end
            if (hold > 0) begin
                @(negedge clk);
                out_ready = 1'b1;
            end
            @(posedge clk);
            #1;
            chk({tag, " out_valid after handshake"}, 32'(out_valid), 32'd0);
            chk({tag, " in_ready after handshake"}, 32'(in_ready), 32'd1);
        end else begin
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        apow = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
                 4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9};

        vecs.push_back(mk(15'h01D1, 4'h0, 4'h0, 15'h01D1, 2'd0, 1'b0));
        vecs.push_back(mk(15'h0020, 4'h6, 4'h1, 15'h0000, 2'd1, 1'b0));
        vecs.push_back(mk(15'h0009, 4'h9, 4'hB, 15'h0000, 2'd2, 1'b0));
        vecs.push_back(mk(15'h0123, 4'h0, 4'h1, 15'h0123, 2'd0, 1'b1));
        // sigma = 1 + x + alpha^3 x^2 has no roots in GF(16)
        vecs.push_back(mk(15'h0400, 4'h1, 4'h9, 15'h0400, 2'd0, 1'b1));
        vecs.push_back(mk_gen(7'h13, 15'h0000));
        vecs.push_back(mk_gen(7'h7F, 15'h4000));
        vecs.push_back(mk_gen(7'h55, 15'h0808));
        vecs.push_back(mk_gen(7'h2A, 15'h4001));
        vecs.push_back(mk_gen(7'h00, 15'h0080));
        vecs.push_back(mk_gen(7'h64, 15'h00C0));

        rst         = 1'b1;
        in_valid    = 1'b0;
        in_codeword = 15'h0;
        in_s1       = 4'h0;
        in_s3       = 4'h0;
        out_ready   = 1'b1;
        #1;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_codeword", 32'(out_codeword), 32'd0);
        chk("reset out_err_cnt", 32'(out_err_cnt), 32'd0);
        chk("reset out_uncorrectable", 32'(out_uncorrectable), 32'd0);
        chk("reset out_message", 32'(out_message), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], 0, $sformatf("vec%0d", i));
        end

        run_vec(vecs[1], 5, "backpressure");
        run_vec(vecs[2], 0, "after backpressure");

        // Reset while the Chien search is at position 7.
        @(negedge clk);
        in_valid    = 1'b1;
        in_codeword = vecs[2].cw;
        in_s1       = vecs[2].s1;
        in_s3       = vecs[2].s3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midreset out_valid", 32'(out_valid), 32'd0);
        chk("midreset in_ready", 32'(in_ready), 32'd1);
        chk("midreset out_codeword", 32'(out_codeword), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(vecs[7], 0, "after midreset");

        chk("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bch_error_corrector.md
Name: bch_error_corrector

Overview:
- Downstream of the BCH syndrome stage: consumes the received 15-bit codeword plus syndromes S1 and S3 for the t=2 BCH(15,7) code over GF(16).
- Solves the error-locator polynomial in closed form (Peterson, t=2), runs a serial Chien search over the 15 bit positions, and flips the located bits.
- Returns the corrected codeword with an error count and an uncorrectable flag on a valid/ready output port.

Parameters:
- N, 15, codeword length; only 15 is supported; other values must fail elaboration.
- K, 7, message length; only 7 is supported.
- GF_POLY, 5'b10011, GF(16) primitive polynomial x^4+x+1 (alpha^4 = 4'b0011).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  codeword+syndromes valid
- in_ready  out  1  block can accept; high only in IDLE
- in_codeword  in  15  received word, bit j = coefficient of x^j
- in_s1  in  4  syndrome S1 = r(alpha), polynomial basis
- in_s3  in  4  syndrome S3 = r(alpha^3)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_codeword  out  15  corrected word
- out_err_cnt  out  2  number of bits flipped (0..2)
- out_uncorrectable  out  1  decode failure; word passed unmodified
- out_message  out  7  quotient codeword/g(x); see optional feature

Behaviour:
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, out_codeword=0, out_err_cnt=0, out_uncorrectable=0, out_message=0. Any in-flight word is discarded.
- Input handshake: transfer on the rising edge where in_valid && in_ready. The word and syndromes are registered at that edge, and in_ready drops on the next cycle.
- FSM: IDLE -> SOLVE -> CHIEN -> [DIVIDE] -> OUTPUT -> IDLE.
- SOLVE (1 cycle):
  - S1==0 and S3==0: no error. deg=0, sigma1=sigma2=0.
  - S1!=0 and S3==S1^3: deg=1, sigma1=S1, sigma2=0.
  - S1!=0, otherwise: deg=2, sigma1=S1, sigma2=(S3 xor S1^3)*inv(S1). Inverse comes from a 16-entry LUT.
  - S1==0 and S3!=0: flag uncorrectable, deg=0. CHIEN still runs but must not modify the word.
- CHIEN (exactly 15 cycles, counter j=0..14):
  - Registers r1=sigma1, r2=sigma2 at j=0.
  - Each cycle, position j is a root iff 1 xor r1 xor r2 == 0 and deg!=0. On a root, flip bit j and increment the root count.
  - After each cycle, r1 <= r1*alpha^14 and r2 <= r2*alpha^13 (constant GF multipliers).
- Chien end check: if the root count != deg, restore the original word, set uncorrectable=1 and err_cnt=root count.
- Latency: out_valid rises 17 clock edges after the input handshake edge without the optional feature, 25 with it.
- OUTPUT:
  - out_valid=1 and all out_* held stable until the edge with out_ready=1.
  - Next cycle: state=IDLE and in_ready=1.
  - out_valid and in_ready are never high together, so there is no simultaneous in/out transfer.
- GF arithmetic: all values are 4-bit polynomial basis. Multiply is shift-and-reduce modulo GF_POLY. S1^3 is computed as S1*S1*S1 within SOLVE.

Optional Feature:
- Macro: BCH_DIVIDE_EN.
- Defined:
  - A DIVIDE state of 8 cycles follows CHIEN and long-divides out_codeword by g(x)=x^8+x^7+x^6+x^4+1, one quotient bit per cycle, MSB first.
  - out_message receives the quotient.
  - A nonzero remainder forces out_uncorrectable=1.
  - Latency is 25 edges.
- Not defined: no DIVIDE state, out_message tied to 0, latency 17 edges.

Test Plan:
- Clean word: in_codeword=15'h01D1, S1=0, S3=0 -> out_codeword=15'h01D1, err_cnt=0, uncorrectable=0. With BCH_DIVIDE_EN, out_message=7'h01.
- Single error: in_codeword=15'h0020, S1=4'b0110, S3=4'b0001 -> out_codeword=0, err_cnt=1, out_valid exactly 17 edges after accept.
- Double error: in_codeword=15'h0009, S1=4'b1001, S3=4'b1011 -> out_codeword=0, err_cnt=2, uncorrectable=0.
- Uncorrectable: in_codeword=15'h0123, S1=0, S3=4'b0001 -> out_codeword=15'h0123, uncorrectable=1, err_cnt=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0 throughout. out_ready=1 -> in_ready=1 on the following cycle and a second word is accepted.
- Reset mid-CHIEN (j=7): assert rst -> out_valid=0, in_ready=1 immediately. Next word decodes correctly with full latency.
